// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative shift-add multiplier / restoring divider that stalls the pipeline.
// Define MULDIV_SIGNED_EN to add the signed_op input and signed MUL/DIV support.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALU_control,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
`ifdef MULDIV_SIGNED_EN
   input  logic             signed_op,
`endif
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);
   localparam int unsigned CW     = $clog2(WIDTH + 1);
   localparam logic [3:0]  OP_MUL = 4'b0100;
   localparam logic [3:0]  OP_DIV = 4'b0101;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state_q;
   logic               busy_q, done_q, dbz_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [CW-1:0]      cnt_q;
   logic               is_div_q, bz_q, neg_q, rneg_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   rem_q, rem_d;

   logic               valid_op, accept, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_res;
   logic [WIDTH-1:0]   quo_res, rem_res;

   assign valid_op = (ALU_control == OP_MUL) || (ALU_control == OP_DIV);
   assign accept   = (state_q == S_IDLE) && start && valid_op && !flush;

`ifdef MULDIV_SIGNED_EN
   assign sa = signed_op & operand_a[WIDTH-1];
   assign sb = signed_op & operand_b[WIDTH-1];
`else
   assign sa = 1'b0;
   assign sb = 1'b0;
`endif
   assign mag_a = sa ? -operand_a : operand_a;
   assign mag_b = sb ? -operand_b : operand_b;

   // MUL: acc = {partial product, remaining multiplier bits}; DIV: acc[W-1:0] shifts dividend out, quotient in.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
   assign div_shift = {rem_q, acc_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mcand_q};
   assign div_ge    = div_shift >= {1'b0, mcand_q};

   always_comb begin
      acc_d = acc_q;
      rem_d = rem_q;
      if (is_div_q) begin
         rem_d = div_ge ? WIDTH'(div_diff) : WIDTH'(div_shift);
         acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
      end else begin
         acc_d = {mul_sum, acc_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod_res = neg_q ? -acc_q : acc_q;
      quo_res  = bz_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem_res  = rneg_q ? -rem_q : rem_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         bz_q     <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
                  cnt_q    <= CW'(WIDTH);
                  is_div_q <= ALU_control[0];
                  bz_q     <= (operand_b == '0);
                  neg_q    <= sa ^ sb;
                  rneg_q   <= sa;
                  rem_q    <= '0;
                  mcand_q  <= ALU_control[0] ? mag_b : mag_a;
                  acc_q    <= {{WIDTH{1'b0}}, (ALU_control[0] ? mag_a : mag_b)};
               end
            end
            S_RUN: begin
               if (flush) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end else begin
                  acc_q <= acc_d;
                  rem_q <= rem_d;
                  cnt_q <= cnt_q - CW'(1);
                  if (cnt_q == CW'(1)) state_q <= S_DONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               if (!flush) begin
                  done_q <= 1'b1;
                  dbz_q  <= is_div_q & bz_q;
                  if (is_div_q) begin
                     hi_q <= rem_res;
                     lo_q <= quo_res;
                  end else begin
                     {hi_q, lo_q} <= prod_res;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign stall       = busy_q | accept;
   assign done        = done_q;
   assign hi          = hi_q;
   assign lo          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic/timing reference model checked every cycle.
// Signed vectors are exercised only when MULDIV_SIGNED_EN is defined.
module tb_muldiv_sequencer;
   localparam int unsigned W      = 32;
   localparam logic [3:0]  OP_MUL = 4'b0100;
   localparam logic [3:0]  OP_DIV = 4'b0101;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    ALU_control = 4'd0;
   logic [W-1:0]  operand_a = '0;
   logic [W-1:0]  operand_b = '0;
   logic          flush = 1'b0;
`ifdef MULDIV_SIGNED_EN
   logic          signed_op = 1'b0;
`endif
   logic          busy, stall, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .ALU_control (ALU_control),
      .operand_a   (operand_a),
      .operand_b   (operand_b),
`ifdef MULDIV_SIGNED_EN
      .signed_op   (signed_op),
`endif
      .flush       (flush),
      .busy        (busy),
      .stall       (stall),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Architectural result {hi,lo} of one operation, from plain arithmetic.
   function automatic logic [63:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                              input logic is_div, input logic sgn);
      longint sa, sb;
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (!is_div) return sgn ? 64'(sa * sb) : ({32'd0, a} * {32'd0, b});
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (sgn) return {32'(sa % sb), 32'(sa / sb)};
      return {a % b, a / b};
   endfunction

   // Transaction-level model: an accepted op occupies W+1 edges, then publishes its result.
   logic          m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
   logic          m_div = 1'b0, m_sgn = 1'b0;
   logic [W-1:0]  m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;
   int            m_left = 0;
   logic [63:0]   m_res;
   logic          valid_in;

   assign valid_in = (ALU_control == OP_MUL) || (ALU_control == OP_DIV);
   assign m_res    = ref_result(m_a, m_b, m_div, m_sgn);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
         m_hi <= '0; m_lo <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start && valid_in && !flush) begin
               m_busy <= 1'b1;
               m_left <= W + 1;
               m_a    <= operand_a;
               m_b    <= operand_b;
               m_div  <= (ALU_control == OP_DIV);
`ifdef MULDIV_SIGNED_EN
               m_sgn  <= signed_op;
`else
               m_sgn  <= 1'b0;
`endif
            end
         end else if (flush) begin
            m_busy <= 1'b0;
         end else if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
            m_dbz  <= m_div && (m_b == '0);
         end else begin
            m_left <= m_left - 1;
         end
      end
   end

   always begin
      @(negedge clk);
      #2;
      chk("busy",  64'(busy),  64'(m_busy));
      chk("done",  64'(done),  64'(m_done));
      chk("stall", 64'(stall), 64'(m_busy || (rst_n && start && valid_in && !flush)));
      chk("hi",    64'(hi),    64'(m_hi));
      chk("lo",    64'(lo),    64'(m_lo));
      chk("dbz",   64'(div_by_zero), 64'(m_dbz));
   end

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; ALU_control = op; operand_a = a; operand_b = b;
      @(negedge clk);
      start = 1'b0; ALU_control = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
   endtask

   task automatic wait_done(input string nm, input int exp_lat);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
   endtask

   task automatic chk_res(input string nm, input logic [31:0] eh, input logic [31:0] el, input logic ez);
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
      chk({nm, "_dbz"}, 64'(div_by_zero), 64'(ez));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit, expected bench completion");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_res("reset", 32'd0, 32'd0, 1'b0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);

      // MUL 7x6 with stall in the issue cycle
      start = 1'b1; ALU_control = OP_MUL; operand_a = 32'd7; operand_b = 32'd6;
      #1 chk("issue_stall", 64'(stall), 64'd1);
      @(negedge clk);
      start = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
      chk("run_stall", 64'(stall), 64'd1);
      wait_done("mul7x6", 33);
      chk_res("mul7x6", 32'd0, 32'd42, 1'b0);
      chk("model_mul7x6", {m_hi, m_lo}, 64'd42);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after", 64'(busy), 64'd0);

      issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done("mulmax", 33);
      chk_res("mulmax", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      chk("model_mulmax", {m_hi, m_lo}, 64'hFFFF_FFFE_0000_0001);

      issue(OP_DIV, 32'd100, 32'd7);
      wait_done("div100_7", 33);
      chk_res("div100_7", 32'd2, 32'd14, 1'b0);

      issue(OP_DIV, 32'h1234, 32'd0);
      wait_done("div0", 33);
      chk_res("div0", 32'h1234, 32'hFFFF_FFFF, 1'b1);
      chk("model_div0", {m_hi, m_lo}, 64'h0000_1234_FFFF_FFFF);

      // flush at T10 of a MUL, then a DIV accepted at T12
      issue(OP_MUL, 32'd5, 32'd9);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy", 64'(busy), 64'd0);
      chk_res("flush_hold", 32'h1234, 32'hFFFF_FFFF, 1'b1);
      @(negedge clk);
      issue(OP_DIV, 32'd1000, 32'd33);
      wait_done("div_after_flush", 33);
      chk_res("div_after_flush", 32'd10, 32'd30, 1'b0);

      // flush during the DONE cycle suppresses the result
      issue(OP_MUL, 32'd11, 32'd13);
      repeat (32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_done_pulse", 64'(done), 64'd0);
      chk_res("flush_done_hold", 32'd10, 32'd30, 1'b0);

      // start together with flush is not accepted
      start = 1'b1; ALU_control = OP_MUL; operand_a = 32'd2; operand_b = 32'd2;
      flush = 1'b1;
      #1 chk("accept_flush_stall", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("accept_flush_busy", 64'(busy), 64'd0);

      // start held high: DONE-cycle start ignored, next accept one edge later
      start = 1'b1; ALU_control = OP_MUL; operand_a = 32'd3; operand_b = 32'd5;
      repeat (40) @(negedge clk);
      start = 1'b0;
      wait_done("b2b", 28);
      chk_res("b2b", 32'd0, 32'd15, 1'b0);

      // boundary divides
      issue(OP_DIV, 32'hFFFF_FFFF, 32'd1);
      wait_done("div_by1", 33);
      chk_res("div_by1", 32'd0, 32'hFFFF_FFFF, 1'b0);
      issue(OP_DIV, 32'd5, 32'd7);
      wait_done("div_small", 33);
      chk_res("div_small", 32'd5, 32'd0, 1'b0);

`ifdef MULDIV_SIGNED_EN
      signed_op = 1'b1;
      issue(OP_MUL, 32'hFFFF_FFF9, 32'd3);
      wait_done("smul", 33);
      chk_res("smul", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("sdiv", 33);
      chk_res("sdiv", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      issue(OP_DIV, 32'hFFFF_FFFB, 32'd0);
      wait_done("sdiv0", 33);
      chk_res("sdiv0", 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
      signed_op = 1'b0;
`endif

      // asynchronous reset at T5 of a DIV
      issue(OP_DIV, 32'd500, 32'd3);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_res("async_reset", 32'd0, 32'd0, 1'b0);
      chk("async_reset_busy", 64'(busy), 64'd0);
      chk("async_reset_stall", 64'(stall), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1; ALU_control = 4'b0010; operand_a = 32'd8; operand_b = 32'd8;
      #1 chk("bad_op_stall", 64'(stall), 64'd0);
      @(negedge clk);
      start = 1'b0;
      chk("bad_op_busy", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
